pwm_duty_meter: RTL and testbench

Receive-side counterpart of the team's PWM generator. Samples an external PWM line and measures its duty cycle over fixed windows of PERIOD clocks. Reports the duty as a tenths value 0..10 (10 = 100 %) and drives a 7-segment digit for it. Used in loopback bring-up to verify the generator's duty steps, one meter per PWM channel.

---
 rtl/pwm_duty_meter_pkg.sv | 14 +
 rtl/pwm_duty_meter_segments.sv | 30 +++
 rtl/pwm_duty_meter.sv | 162 ++++++++++++++++
 tb/tb_pwm_duty_meter.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/pwm_duty_meter_pkg.sv
// Shared types and constants for the PWM duty meter.
// The optional stuck detector is enabled with PWM_DUTY_METER_STUCK_EN.
package pwm_duty_meter_pkg;

    localparam int DUTY_W   = 4;
    localparam int DUTY_MAX = 10;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        DONE
    } div_state_t;

endpackage

// File: rtl/pwm_duty_meter_segments.sv
// Hex digit to active-low 7-segment pattern, bit order a..g from MSB to LSB.
module segments_decoder (
    input  logic [3:0] i_val,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = 7'b1111111;
        case (i_val)
            4'h0: o_seg = 7'b0000001;
            4'h1: o_seg = 7'b1001111;
            4'h2: o_seg = 7'b0010010;
            4'h3: o_seg = 7'b0000110;
            4'h4: o_seg = 7'b1001100;
            4'h5: o_seg = 7'b0100100;
            4'h6: o_seg = 7'b0100000;
            4'h7: o_seg = 7'b0001111;
            4'h8: o_seg = 7'b0000000;
            4'h9: o_seg = 7'b0000100;
            4'hA: o_seg = 7'b0001000;
            4'hB: o_seg = 7'b1100000;
            4'hC: o_seg = 7'b0110001;
            4'hD: o_seg = 7'b1000010;
            4'hE: o_seg = 7'b0110000;
            4'hF: o_seg = 7'b0111000;
            default: o_seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/pwm_duty_meter.sv
// Measures PWM duty in tenths over fixed PERIOD-clock windows.
// Define PWM_DUTY_METER_STUCK_EN to add the stuck (no-edge window) output.
module pwm_duty_meter
    import pwm_duty_meter_pkg::*;
#(
    parameter int PERIOD = 2_000_000,
    parameter int CNT_W  = $clog2(PERIOD + 1) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pwm_in,
    output logic [DUTY_W-1:0] duty,
    output logic              duty_valid,
`ifdef PWM_DUTY_METER_STUCK_EN
    output logic [6:0]        segments,
    output logic              stuck
`else
    output logic [6:0]        segments
`endif
);

    localparam logic [CNT_W-1:0]  LAST_C = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0]  STEP_C = CNT_W'(PERIOD / 10);
    localparam logic [CNT_W-1:0]  HALF_C = CNT_W'(PERIOD / 20);
    localparam logic [DUTY_W-1:0] QMAX_C = DUTY_W'(DUTY_MAX);

    logic              r_pwm_meta;
    logic              r_pwm_s;
    logic [CNT_W-1:0]  r_win_cnt;
    logic [CNT_W-1:0]  r_hi_cnt;
    logic [CNT_W-1:0]  r_acc;
    logic [DUTY_W-1:0] r_q;
    logic [DUTY_W-1:0] r_duty;
    div_state_t        r_state;
    div_state_t        w_state_nxt;
    logic              w_win_end;
    logic              w_ge_step;
    logic [CNT_W-1:0]  w_sample;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm_meta <= 1'b0;
            r_pwm_s    <= 1'b0;
        end else begin
            r_pwm_meta <= pwm_in;
            r_pwm_s    <= r_pwm_meta;
        end
    end

    assign w_win_end = (r_win_cnt == LAST_C);
    // Include the window's final sample so a steady input is phase independent
    assign w_sample  = r_hi_cnt + CNT_W'(r_pwm_s);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_win_cnt <= '0;
            r_hi_cnt  <= '0;
        end else if (w_win_end) begin
            r_win_cnt <= '0;
            r_hi_cnt  <= '0;
        end else begin
            r_win_cnt <= r_win_cnt + CNT_W'(1);
            r_hi_cnt  <= w_sample;
        end
    end

    assign w_ge_step = (r_acc >= STEP_C) && (r_q != QMAX_C);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_win_end) begin
                    w_state_nxt = DIV;
                end
            end
            DIV: begin
                if (!w_ge_step) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Repeated subtraction; duty lands together with the DONE-cycle pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc  <= '0;
            r_q    <= '0;
            r_duty <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_win_end) begin
                        r_acc <= w_sample + HALF_C;
                        r_q   <= '0;
                    end
                end
                DIV: begin
                    if (w_ge_step) begin
                        r_acc <= r_acc - STEP_C;
                        r_q   <= r_q + DUTY_W'(1);
                    end else begin
                        r_duty <= r_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign duty       = r_duty;
    assign duty_valid = (r_state == DONE);

    segments_decoder u_seg (
        .i_val (r_duty),
        .o_seg (segments)
    );

`ifdef PWM_DUTY_METER_STUCK_EN
    logic r_pwm_d;
    logic r_edge_seen;
    logic r_stuck;
    logic w_edge;

    assign w_edge = r_pwm_s ^ r_pwm_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm_d     <= 1'b0;
            r_edge_seen <= 1'b0;
            r_stuck     <= 1'b0;
        end else begin
            r_pwm_d <= r_pwm_s;
            if (w_win_end) begin
                r_stuck     <= ~(r_edge_seen | w_edge);
                r_edge_seen <= 1'b0;
            end else begin
                r_edge_seen <= r_edge_seen | w_edge;
            end
        end
    end

    assign stuck = r_stuck;
`endif

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Randomized bench for pwm_duty_meter against a window-sum reference model.
// Define PWM_DUTY_METER_STUCK_EN to also check the stuck output.
module tb_pwm_duty_meter;

    localparam int PERIOD = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pwm_in = 1'b0;
    logic [3:0] duty;
    logic       duty_valid;
    logic [6:0] segments;
`ifdef PWM_DUTY_METER_STUCK_EN
    logic       stuck;
`endif

    always #5 clk = ~clk;

    pwm_duty_meter #(
        .PERIOD (PERIOD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pwm_in     (pwm_in),
        .duty       (duty),
        .duty_valid (duty_valid),
`ifdef PWM_DUTY_METER_STUCK_EN
        .segments   (segments),
        .stuck      (stuck)
`else
        .segments   (segments)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    logic [6:0] seg_ref [0:10] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000
    };

    // Reference: 2-cycle delayed input stream summed over PERIOD-sample windows
    int cyc = 0;
    int pos = 0;
    int hi = 0;
    int edges = 0;
    bit d0 = 0;
    bit d1 = 0;
    bit prev = 0;
    bit pend = 0;
    int pend_edge = 0;
    int pend_q = 0;
    int m_duty = 0;
    bit m_valid = 0;
    bit m_stuck = 0;
    int m_pulses = 0;
    int d_pulses = 0;

    always @(posedge clk) begin
        bit s;
        cyc++;
        if (rst) begin
            pos = 0; hi = 0; edges = 0;
            d0 = 0; d1 = 0; prev = 0;
            pend = 0; m_duty = 0; m_valid = 0; m_stuck = 0;
        end else begin
            s = d1;
            d1 = d0;
            d0 = pwm_in;
            hi += int'(s);
            if (s != prev) edges++;
            prev = s;
            m_valid = 0;
            if (pend && cyc == pend_edge) begin
                m_duty = pend_q;
                m_valid = 1;
                pend = 0;
                m_pulses++;
            end
            if (pos == PERIOD - 1) begin
                pend_q = (hi * 10 + PERIOD / 2) / PERIOD;
                pend_edge = cyc + pend_q + 1;
                pend = 1;
                m_stuck = (edges == 0);
                hi = 0;
                edges = 0;
                pos = 0;
            end else begin
                pos++;
            end
        end
    end

    always @(negedge clk) begin
        chk("valid", 16'(duty_valid), 16'(m_valid));
        chk("duty", 16'(duty), 16'(m_duty));
        chk("seg", 16'(segments), 16'(seg_ref[m_duty]));
`ifdef PWM_DUTY_METER_STUCK_EN
        chk("stuck", 16'(stuck), 16'(m_stuck));
`endif
        if (duty_valid === 1'b1) d_pulses++;
    end

    int hi_len = 0;
    int ph = 0;
    bit noise = 0;

    task automatic step();
        @(negedge clk);
        pwm_in = noise ? 1'($urandom) : (ph < hi_len);
        ph = (ph + 1) % PERIOD;
    endtask

    task automatic run(input int h, input int w);
        hi_len = h;
        noise = 0;
        repeat (w * PERIOD) step();
    endtask

    initial begin
        int n;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        ph = $urandom_range(0, PERIOD - 1);

        run(60, 4);
        run(90, 3);
        run(88, 3);
        run(9, 3);
        run(PERIOD, 3);
        run(0, 3);
        for (int i = 0; i < 6; i++) begin
            run($urandom_range(0, PERIOD), 2);
        end
        noise = 1;
        repeat (2 * PERIOD) step();

        // Reset pulse while dividing a 70 % measurement
        run(140, 2);
        n = 0;
        while (pend && n < 2 * PERIOD) begin step(); n++; end
        n = 0;
        while (!pend && n < 2 * PERIOD) begin step(); n++; end
        chk("div_wait", 16'(pend), 16'd1);
        repeat (2) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        run(140, 3);

`ifdef PWM_DUTY_METER_STUCK_EN
        run(0, 2);
        run(100, 2);
`endif
        run(PERIOD / 2, 1);

        @(negedge clk);
        #1;
        chk("pulses", 16'(d_pulses), 16'(m_pulses));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
